// File: rtl/ex_mem_wb_pipe.sv
// ex_mem_wb_pipe: EX/MEM and MEM/WB pipeline registers of the MIPS core.
// Feeds the forwarding unit (next_rd/data1 one stage ahead, next_next_rd/data2
// two stages ahead) and drives the register-file write port.
// Optional feature macro: LOAD_USE_DET_EN (load-use hazard detection toward ID).
module ex_mem_wb_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    output logic [REG_W-1:0]  next_rd,
    output logic              next_is_load,
    output logic [DATA_W-1:0] data1,
    output logic [REG_W-1:0]  next_next_rd,
    output logic [DATA_W-1:0] data2,
    output logic              wb_we,
    output logic              load_use_stall
);

    localparam logic [REG_W-1:0]  RD_ZERO   = {REG_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    // EX/MEM stage state
    logic              exm_valid_q, exm_valid_d;
    logic              exm_regwrite_q, exm_regwrite_d;
    logic              exm_memread_q, exm_memread_d;
    logic [REG_W-1:0]  exm_rd_q, exm_rd_d;
    logic [DATA_W-1:0] exm_result_q, exm_result_d;

    // MEM/WB stage state; mwb_wr_q already folds valid & regwrite together
    logic              mwb_wr_q, mwb_wr_d;
    logic [REG_W-1:0]  mwb_rd_q, mwb_rd_d;
    logic [DATA_W-1:0] mwb_data_q, mwb_data_d;

    // Next-state selection: hold beats flush, flush only bubbles EX/MEM
    always_comb begin
        exm_valid_d    = exm_valid_q;
        exm_regwrite_d = exm_regwrite_q;
        exm_memread_d  = exm_memread_q;
        exm_rd_d       = exm_rd_q;
        exm_result_d   = exm_result_q;
        mwb_wr_d       = mwb_wr_q;
        mwb_rd_d       = mwb_rd_q;
        mwb_data_d     = mwb_data_q;
        if (hold) begin
            exm_valid_d = exm_valid_q;
        end else begin
            if (flush) begin
                exm_valid_d    = 1'b0;
                exm_regwrite_d = 1'b0;
                exm_memread_d  = 1'b0;
                exm_rd_d       = RD_ZERO;
                exm_result_d   = DATA_ZERO;
            end else begin
                exm_valid_d    = ex_valid;
                exm_regwrite_d = ex_regwrite;
                exm_memread_d  = ex_memread;
                exm_rd_d       = ex_rd;
                exm_result_d   = ex_result;
            end
            mwb_wr_d = exm_valid_q & exm_regwrite_q;
            mwb_rd_d = exm_rd_q;
            if (exm_memread_q) begin
                mwb_data_d = mem_rdata;
            end else begin
                mwb_data_d = exm_result_q;
            end
        end
    end

    // Pipeline state registers; reset discards both stages immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exm_valid_q    <= 1'b0;
            exm_regwrite_q <= 1'b0;
            exm_memread_q  <= 1'b0;
            exm_rd_q       <= RD_ZERO;
            exm_result_q   <= DATA_ZERO;
            mwb_wr_q       <= 1'b0;
            mwb_rd_q       <= RD_ZERO;
            mwb_data_q     <= DATA_ZERO;
        end else begin
            exm_valid_q    <= exm_valid_d;
            exm_regwrite_q <= exm_regwrite_d;
            exm_memread_q  <= exm_memread_d;
            exm_rd_q       <= exm_rd_d;
            exm_result_q   <= exm_result_d;
            mwb_wr_q       <= mwb_wr_d;
            mwb_rd_q       <= mwb_rd_d;
            mwb_data_q     <= mwb_data_d;
        end
    end

    // Forwarding and writeback outputs; $0 is never a forwarding source
    always_comb begin
        next_rd      = RD_ZERO;
        next_next_rd = RD_ZERO;
        if (exm_valid_q && exm_regwrite_q && (exm_rd_q != RD_ZERO)) begin
            next_rd = exm_rd_q;
        end else begin
            next_rd = RD_ZERO;
        end
        if (mwb_wr_q && (mwb_rd_q != RD_ZERO)) begin
            next_next_rd = mwb_rd_q;
        end else begin
            next_next_rd = RD_ZERO;
        end
        wb_we        = mwb_wr_q & (mwb_rd_q != RD_ZERO);
        next_is_load = exm_valid_q & exm_memread_q;
        data1        = exm_result_q;
        data2        = mwb_data_q;
    end

`ifdef LOAD_USE_DET_EN
    // Load in EX whose destination is a source of the ID instruction; quiet during reset
    always_comb begin
        load_use_stall = 1'b0;
        if (rst_n && ex_valid && ex_memread && ex_regwrite && (ex_rd != RD_ZERO)
            && ((ex_rd == id_rs) || (ex_rd == id_rt))) begin
            load_use_stall = 1'b1;
        end else begin
            load_use_stall = 1'b0;
        end
    end
`else
    // Hazard handled in software; ID source registers are not observed
    logic unused_id_regs_s;
    assign unused_id_regs_s = ^{id_rs, id_rt};
    assign load_use_stall   = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// tb_ex_mem_wb_pipe: directed scoreboard bench for ex_mem_wb_pipe.
module tb_ex_mem_wb_pipe;

`ifdef LOAD_USE_DET_EN
    localparam bit LUD = 1'b1;
`else
    localparam bit LUD = 1'b0;
`endif

    logic        clk, rst_n, hold, flush;
    logic        ex_valid, ex_regwrite, ex_memread;
    logic [4:0]  ex_rd, id_rs, id_rt;
    logic [31:0] ex_result, mem_rdata;
    logic [4:0]  next_rd, next_next_rd;
    logic        next_is_load, wb_we, load_use_stall;
    logic [31:0] data1, data2;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string       tag;
        logic [4:0]  nrd;
        logic [31:0] d1;
        logic        nl;
        logic [4:0]  nnrd;
        logic [31:0] d2;
        logic        we;
        logic        lus;
    } exp_t;

    exp_t sb[$];

    ex_mem_wb_pipe #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .ex_result(ex_result), .mem_rdata(mem_rdata),
        .id_rs(id_rs), .id_rt(id_rt),
        .next_rd(next_rd), .next_is_load(next_is_load), .data1(data1),
        .next_next_rd(next_next_rd), .data2(data2), .wb_we(wb_we),
        .load_use_stall(load_use_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_out(input string tag, input logic [4:0] nrd, input logic [31:0] d1,
                              input logic nl, input logic [4:0] nnrd, input logic [31:0] d2,
                              input logic we, input logic lus);
        exp_t e;
        e.tag = tag; e.nrd = nrd; e.d1 = d1; e.nl = nl;
        e.nnrd = nnrd; e.d2 = d2; e.we = we; e.lus = lus;
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        tests_run++;
        assert (sb.size() > 0) else begin
            tests_failed++;
            $error("FAIL scoreboard_empty: observed 0 entries expected >0");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp({e.tag, ".next_rd"},        {27'd0, next_rd},        {27'd0, e.nrd});
            cmp({e.tag, ".data1"},          data1,                   e.d1);
            cmp({e.tag, ".next_is_load"},   {31'd0, next_is_load},   {31'd0, e.nl});
            cmp({e.tag, ".next_next_rd"},   {27'd0, next_next_rd},   {27'd0, e.nnrd});
            cmp({e.tag, ".data2"},          data2,                   e.d2);
            cmp({e.tag, ".wb_we"},          {31'd0, wb_we},          {31'd0, e.we});
            cmp({e.tag, ".load_use_stall"}, {31'd0, load_use_stall}, {31'd0, e.lus});
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic mr, input logic [4:0] rd,
                         input logic [31:0] res, input logic [31:0] rdata);
        ex_valid = v; ex_regwrite = rw; ex_memread = mr;
        ex_rd = rd; ex_result = res; mem_rdata = rdata;
    endtask

    task automatic edge_check();
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
        id_rs = 5'd7; id_rt = 5'd0;
        drive(1'b1, 1'b1, 1'b1, 5'd7, 32'd99, 32'd5);

        // Reset held across an edge with a live load in EX
        expect_out("reset", 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        edge_check();

        // Release between edges: still all zero
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        id_rs = 5'd0;
        rst_n = 1'b1;
        #1;
        expect_out("post_release", 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check_out();

        // ALU op rd=8, result=56
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 5'd8, 32'd56, 32'd0);
        expect_out("alu_e1", 5'd8, 32'd56, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        edge_check();

        // Load rd=23 at 0x100; ID reads $23 through rt
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 5'd23, 32'h100, 32'd777);
        id_rt = 5'd23;
        expect_out("load_e1", 5'd23, 32'h100, 1'b1, 5'd8, 32'd56, 1'b1, LUD);
        edge_check();

        // $0 write while the load is in EX/MEM with mem_rdata=234
        @(negedge clk);
        id_rt = 5'd0;
        drive(1'b1, 1'b1, 1'b0, 5'd0, 32'd43214, 32'd234);
        expect_out("zero_e1", 5'd0, 32'd43214, 1'b0, 5'd23, 32'd234, 1'b1, 1'b0);
        edge_check();

        // ALU op rd=5; the $0 write reaches MEM/WB without a write enable
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 5'd5, 32'h55, 32'd1);
        expect_out("zero_e2", 5'd5, 32'h55, 1'b0, 5'd0, 32'd43214, 1'b0, 1'b0);
        edge_check();

        // hold together with flush: nothing moves
        @(negedge clk);
        hold = 1'b1; flush = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 5'd9, 32'd9, 32'd2);
        expect_out("hold_flush", 5'd5, 32'h55, 1'b0, 5'd0, 32'd43214, 1'b0, 1'b0);
        edge_check();

        // flush alone: bubble in EX/MEM, old EX/MEM moves to MEM/WB
        @(negedge clk);
        hold = 1'b0;
        expect_out("flush", 5'd0, 32'd0, 1'b0, 5'd5, 32'h55, 1'b1, 1'b0);
        edge_check();

        // regwrite=0 instruction
        @(negedge clk);
        flush = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 5'd9, 32'h99, 32'd3);
        expect_out("norw", 5'd0, 32'h99, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        edge_check();

        // invalid instruction still carries data
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 5'd10, 32'hA, 32'd4);
        expect_out("invalid", 5'd0, 32'hA, 1'b0, 5'd0, 32'h99, 1'b0, 1'b0);
        edge_check();

        // Load rd=3, then reset asserted mid-flight between edges
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 5'd3, 32'h200, 32'd6);
        expect_out("load2", 5'd3, 32'h200, 1'b1, 5'd0, 32'hA, 1'b0, 1'b0);
        edge_check();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        expect_out("midreset", 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check_out();
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        rst_n = 1'b1;
        expect_out("after_midreset", 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        edge_check();

        // Load-use detection on combinational inputs
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 5'd11, 32'd0, 32'd0);
        id_rs = 5'd0; id_rt = 5'd11;
        #1;
        cmp("lu_rt_match", {31'd0, load_use_stall}, {31'd0, LUD});
        id_rt = 5'd12;
        #1;
        cmp("lu_no_match", {31'd0, load_use_stall}, 32'd0);
        id_rs = 5'd11;
        #1;
        cmp("lu_rs_match", {31'd0, load_use_stall}, {31'd0, LUD});
        ex_regwrite = 1'b0;
        #1;
        cmp("lu_no_regwrite", {31'd0, load_use_stall}, 32'd0);
        ex_regwrite = 1'b1; ex_memread = 1'b0;
        #1;
        cmp("lu_not_load", {31'd0, load_use_stall}, 32'd0);
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        #1;
        cmp("lu_rd_zero", {31'd0, load_use_stall}, 32'd0);

        cmp("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
